// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO
// standard or first-word-fall-through read, flush, count and flags
module fifo_param #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  input  logic                     wr,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic                     almostfull,
  output logic                     empty,
  output logic                     almostempty,
  output logic                     over,
  output logic                     under,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (WIDTH < 1 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 ||
      AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1)
  begin : g_bad_param
    $error("fifo_param: illegal parameters");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_ok;
  logic             rd_ok;
  logic [CW-1:0]    count_nx;

  // accept decisions use the registered pre-edge flags
  always_comb begin
    wr_ok    = wr & (~full | rd);
    rd_ok    = rd & ~empty;
    count_nx = count + CW'(wr_ok) - CW'(rd_ok);
  end

  // storage array, deliberately left out of reset
  always_ff @(posedge clk) begin
    if (!flush && wr_ok)
      mem[wptr] <= din;
  end

  // pointers, occupancy and registered flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      full        <= 1'b0;
      almostfull  <= 1'b0;
      empty       <= 1'b1;
      almostempty <= 1'b1;
      over        <= 1'b0;
      under       <= 1'b0;
    end else if (flush) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      full        <= 1'b0;
      almostfull  <= 1'b0;
      empty       <= 1'b1;
      almostempty <= 1'b1;
      over        <= 1'b0;
      under       <= 1'b0;
    end else begin
      if (wr_ok)
        wptr <= wptr + 1'b1;
      if (rd_ok)
        rptr <= rptr + 1'b1;
      count       <= count_nx;
      full        <= (count_nx == CW'(DEPTH));
      almostfull  <= (count_nx >= CW'(AF_THRESH));
      empty       <= (count_nx == '0);
      almostempty <= (count_nx <= CW'(AE_THRESH));
      over        <= wr & ~wr_ok;
      under       <= rd & ~rd_ok;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // head word is always presented; zero while empty
    always_comb begin
      dout  = empty ? '0 : mem[rptr];
      valid = ~empty;
    end
  end else begin : g_std
    // one-cycle read latency, dout holds between reads
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout  <= '0;
        valid <= 1'b0;
      end else if (flush) begin
        valid <= 1'b0;
      end else begin
        valid <= rd_ok;
        if (rd_ok)
          dout <= mem[rptr];
      end
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: standard and FWFT instances driven in lockstep
// against a queue scoreboard and occupancy model
module tb_fifo_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        wr;
  logic        rd;
  logic [15:0] din;

  logic [15:0] s_dout, f_dout;
  logic        s_valid, f_valid;
  logic        s_full, f_full;
  logic        s_af, f_af;
  logic        s_empty, f_empty;
  logic        s_ae, f_ae;
  logic        s_over, f_over;
  logic        s_under, f_under;
  logic [3:0]  s_count, f_count;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] q[$];
  int          mcnt   = 0;

  fifo_param #(
    .WIDTH(16), .DEPTH(8), .AF_THRESH(6),
    .AE_THRESH(1), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .flush(flush),
    .din(din), .wr(wr), .rd(rd),
    .dout(s_dout), .valid(s_valid),
    .full(s_full), .almostfull(s_af),
    .empty(s_empty), .almostempty(s_ae),
    .over(s_over), .under(s_under),
    .count(s_count)
  );

  fifo_param #(
    .WIDTH(16), .DEPTH(8), .AF_THRESH(6),
    .AE_THRESH(1), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .flush(flush),
    .din(din), .wr(wr), .rd(rd),
    .dout(f_dout), .valid(f_valid),
    .full(f_full), .almostfull(f_af),
    .empty(f_empty), .almostempty(f_ae),
    .over(f_over), .under(f_under),
    .count(f_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
  endtask

  function automatic logic [5:0] flags_exp(
    int c, logic ov, logic un);
    return {c == 8, c >= 6, c == 0,
            c <= 1, ov, un};
  endfunction

  task automatic check_reset(string tag);
    logic [5:0] fe;
    fe = flags_exp(0, 1'b0, 1'b0);
    chk({tag, "_cnt"}, 32'(s_count), 0);
    chk({tag, "_fcnt"}, 32'(f_count), 0);
    chk({tag, "_flags"},
        32'({s_full, s_af, s_empty,
             s_ae, s_over, s_under}), 32'(fe));
    chk({tag, "_fflags"},
        32'({f_full, f_af, f_empty,
             f_ae, f_over, f_under}), 32'(fe));
    chk({tag, "_valid"}, 32'(s_valid), 0);
    chk({tag, "_fvalid"}, 32'(f_valid), 0);
    chk({tag, "_dout"}, 32'(s_dout), 0);
    chk({tag, "_fdout"}, 32'(f_dout), 0);
  endtask

  // one clock of stimulus followed by full output check
  task automatic step(logic w, logic [15:0] d,
                      logic r, logic f);
    logic        wok, rok, ov, un;
    logic [15:0] hd;
    logic [5:0]  fe;
    @(negedge clk);
    wr    = w;
    din   = d;
    rd    = r;
    flush = f;
    wok = w && (mcnt != 8 || r);
    rok = r && (mcnt != 0);
    hd  = '0;
    @(posedge clk);
    #1;
    if (f) begin
      q.delete();
      mcnt = 0;
      wok  = 1'b0;
      rok  = 1'b0;
      ov   = 1'b0;
      un   = 1'b0;
    end else begin
      ov = w && !wok;
      un = r && !rok;
      if (rok)
        hd = q.pop_front();
      if (wok)
        q.push_back(d);
      mcnt += int'(wok) - int'(rok);
    end
    fe = flags_exp(mcnt, ov, un);
    chk("cnt", 32'(s_count), 32'(mcnt));
    chk("fcnt", 32'(f_count), 32'(mcnt));
    chk("flags",
        32'({s_full, s_af, s_empty,
             s_ae, s_over, s_under}), 32'(fe));
    chk("fflags",
        32'({f_full, f_af, f_empty,
             f_ae, f_over, f_under}), 32'(fe));
    chk("valid", 32'(s_valid), 32'(rok));
    if (rok)
      chk("dout", 32'(s_dout), 32'(hd));
    chk("fvalid", 32'(f_valid), 32'(mcnt != 0));
    if (mcnt != 0)
      chk("fdout", 32'(f_dout), 32'(q[0]));
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    din   = '0;
    #12;
    check_reset("rst");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 1; i <= 8; i++)
      step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);

    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 16'h00AA, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++)
      step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      step(1'b1, 16'h1234, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);

    step(1'b1, 16'h0011, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++)
      step(1'b1, 16'h0050 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++)
      step(1'b1, 16'h0070 + 16'(i), 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    @(negedge clk);
    wr    = 1'b1;
    din   = 16'h0077;
    flush = 1'b0;
    rd    = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset("arst");
    wr = 1'b0;
    rd = 1'b0;
    #1 rst = 1'b0;
    q.delete();
    mcnt = 0;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0099, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the 16-bit x 8 FIFO.
- Adds configurable width, depth and almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) mode, an occupancy count and a synchronous flush.
- Sits between producer/consumer stages in the datapath as a drop-in buffer with the same flag set plus extensions.

Parameters:
- WIDTH, 16, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AF_THRESH, DEPTH-2, almostFULL asserted when COUNT >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almostEMPTY asserted when COUNT <= AE_THRESH (0..DEPTH-1).
- FWFT, 0, 0 = standard read (data one cycle after RD); 1 = first-word-fall-through.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- FLUSH  in  1  synchronous clear of contents; takes priority over WR/RD.
- DIN  in  WIDTH  write data.
- WR  in  1  write request.
- RD  in  1  read request (standard) / pop (FWFT).
- DOUT  out  WIDTH  read data.
- VALID  out  1  DOUT holds valid data (pulse in standard mode, level in FWFT).
- FULL  out  1  COUNT == DEPTH.
- almostFULL  out  1  COUNT >= AF_THRESH.
- EMPTY  out  1  COUNT == 0.
- almostEMPTY  out  1  COUNT <= AE_THRESH.
- OVER  out  1  one-cycle pulse: rejected write.
- UNDER  out  1  one-cycle pulse: rejected read.
- COUNT  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage:
  - DEPTH x WIDTH array, not reset.
  - Read/write pointers are clog2(DEPTH) bits; they wrap naturally from DEPTH-1 to 0.
- Reset values (RST=1, applied immediately):
  - Pointers = 0, COUNT = 0, EMPTY = 1, almostEMPTY = 1, FULL = 0.
  - almostFULL = 0 (AF_THRESH >= 1), VALID = 0, OVER = 0, UNDER = 0, DOUT = 0.
- Accept rules, evaluated each rising edge on the pre-edge state:
  - wr_ok = WR & (!FULL | RD)
  - rd_ok = RD & !EMPTY
- Simultaneous RD+WR:
  - When FULL: both accepted, COUNT unchanged, no OVER.
  - When EMPTY: write accepted, read rejected (UNDER pulses in both modes), COUNT becomes 1.
- Rejected operations:
  - WR & !wr_ok: data dropped, pointers unchanged, OVER=1 for the following cycle.
  - RD & !rd_ok: pointers unchanged, UNDER=1 for the following cycle.
- COUNT update: COUNT += wr_ok - rd_ok.
  - All flags are registered and reflect the post-edge COUNT; no combinational path from WR/RD to flags.
- Standard mode (FWFT=0):
  - On rd_ok, DOUT <= mem[rptr] and VALID=1 for exactly one cycle after the edge.
  - Otherwise VALID=0 and DOUT holds its last value.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - DOUT = mem[rptr] at all times.
  - VALID = !EMPTY (level).
  - RD with VALID=1 pops the head word; the next word appears after the same edge.
  - A write into an empty FIFO makes VALID=1 and DOUT=written word after that edge (1-cycle latency).
- FLUSH=1 at an edge:
  - Pointers = 0, COUNT = 0, flags as at reset, VALID = 0.
  - WR/RD in that cycle are ignored; no OVER/UNDER generated.
- Asynchronous reset asserted mid-burst: state clears immediately; operations in progress are lost; no pulse is generated on release.
- Invalid parameter values (non-power-of-two DEPTH, thresholds out of range) must be stopped by an elaboration-time check.

Test Plan (WIDTH=16, DEPTH=8, AF_THRESH=6, AE_THRESH=1 unless noted):
- Reset then write 0x0001..0x0008, one per cycle:
  - COUNT steps 1..8; almostEMPTY drops after 2nd write; almostFULL rises after 6th; FULL after 8th; EMPTY=0 after 1st.
- Ninth write 0xDEAD while FULL:
  - OVER=1 for one cycle, COUNT stays 8.
  - Subsequent 8 reads (FWFT=0) return 0x0001..0x0008, each with a 1-cycle VALID pulse; EMPTY=1 after the last.
- RD on empty FIFO:
  - UNDER=1 one cycle, VALID=0, COUNT=0.
  - RD+WR 0x00AA on empty: UNDER=1, COUNT=1, next read returns 0x00AA.
- Fill to 8, then RD+WR 0x1234 together for 12 cycles:
  - COUNT stays 8, no OVER; pointers wrap past 7; drained sequence ends ...,0x1234 in order.
- FWFT=1: write 0x0011 into empty FIFO:
  - VALID=1 and DOUT=0x0011 after that edge without RD.
  - Write 0x0022, then pulse RD: DOUT=0x0022, VALID stays 1; second RD: VALID=0, EMPTY=1.
- Write 5 words, assert FLUSH with WR=1 and RD=1:
  - COUNT=0, EMPTY=1, no OVER/UNDER.
  - Assert RST asynchronously mid-write: all outputs return to reset values before the next clock edge.
